// File: rtl/rgb_expand_dim.sv
// rgb_expand_dim: expands packed RGB to 24-bit {R8,B8,G8} through a 2-stage pipeline and applies
// a frame-synchronous multi-level dimming fade. Define RGB_DIM_WINDOW_EN to exempt the highlight window.
module rgb_expand_dim #(
    parameter int IN_BITS     = 4,
    parameter int CW          = 12,
    parameter int WIN_X0      = 283,
    parameter int WIN_Y0      = 220,
    parameter int WIN_X1      = 483,
    parameter int WIN_Y1      = 355,
    parameter int DIM_MAX     = 2,
    parameter int FADE_FRAMES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [3*IN_BITS-1:0]             pix_in,
    input  logic                             pix_valid,
    input  logic [CW-1:0]                    hdata,
    input  logic [CW-1:0]                    vdata,
    input  logic                             frame_start,
    input  logic                             to_black,
    output logic [23:0]                      rgb888,
    output logic                             rgb_valid,
    output logic [$clog2(DIM_MAX+1)-1:0]     dim_level,
    output logic                             fade_busy
);
    localparam int LW   = $clog2(DIM_MAX + 1);
    localparam int CNTW = $clog2(FADE_FRAMES + 1);

    // Bit 1 of the encoding marks the two fading states, so fade_busy is a plain register bit.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DIMMED   = 2'b01,
        ST_FADE_IN  = 2'b10,
        ST_FADE_OUT = 2'b11
    } state_e;

    state_e               state_q, state_d, fade_st_s, settle_st_s;
    logic [LW-1:0]        level_q, level_d, target_s, step_level_s;
    logic [CNTW-1:0]      cnt_q, cnt_d, cnt_inc_s;
    logic                 in_window_s;
    logic                 s1_valid_q;
    logic [3*IN_BITS-1:0] s1_pix_q;
    logic                 s1_win_q;
    logic [LW-1:0]        s1_lvl_q;
    logic [LW-1:0]        eff_lvl_s;
    logic [23:0]          rgb_d, rgb_q;
    logic                 rgb_valid_q;

    function automatic logic [IN_BITS-1:0] dim_ch(input logic [IN_BITS-1:0] c, input logic [LW-1:0] l);
        logic [IN_BITS-1:0] lx;
        lx = IN_BITS'(l);
        return (c > lx) ? (c - lx) : {IN_BITS{1'b0}};
    endfunction

    function automatic logic [7:0] expand8(input logic [IN_BITS-1:0] c);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[IN_BITS-1-(i%IN_BITS)];
        end
        return e;
    endfunction

`ifdef RGB_DIM_WINDOW_EN
    localparam logic [CW-1:0] X0 = CW'(WIN_X0);
    localparam logic [CW-1:0] Y0 = CW'(WIN_Y0);
    localparam logic [CW-1:0] X1 = CW'(WIN_X1);
    localparam logic [CW-1:0] Y1 = CW'(WIN_Y1);

    // Inclusive highlight-window test.
    always_comb begin
        in_window_s = (hdata >= X0) && (hdata <= X1) && (vdata >= Y0) && (vdata <= Y1);
    end
`else
    logic unused_coord_s;
    assign unused_coord_s = ^{hdata, vdata, CW'(WIN_X0), CW'(WIN_Y0), CW'(WIN_X1), CW'(WIN_Y1)};

    // Without the window feature every pixel is dimmed.
    always_comb begin
        in_window_s = 1'b0;
    end
`endif

    // Fade FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= {LW{1'b0}};
            cnt_q   <= {CNTW{1'b0}};
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fade next state: a direction change restarts the frame count at 1.
    always_comb begin
        target_s     = to_black ? LW'(DIM_MAX) : {LW{1'b0}};
        fade_st_s    = to_black ? ST_FADE_IN : ST_FADE_OUT;
        settle_st_s  = to_black ? ST_DIMMED : ST_IDLE;
        step_level_s = to_black ? (level_q + LW'(1)) : (level_q - LW'(1));
        cnt_inc_s    = (state_q == fade_st_s) ? (cnt_q + CNTW'(1)) : CNTW'(1);
        state_d      = state_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        if (!frame_start) begin
            state_d = state_q;
        end else if (level_q == target_s) begin
            state_d = settle_st_s;
            cnt_d   = {CNTW{1'b0}};
        end else if (cnt_inc_s >= CNTW'(FADE_FRAMES)) begin
            level_d = step_level_s;
            cnt_d   = {CNTW{1'b0}};
            state_d = (step_level_s == target_s) ? settle_st_s : fade_st_s;
        end else begin
            cnt_d   = cnt_inc_s;
            state_d = fade_st_s;
        end
    end

    // Stage 1: capture pixel, window flag and the level in force before any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= {(3*IN_BITS){1'b0}};
            s1_win_q   <= 1'b0;
            s1_lvl_q   <= {LW{1'b0}};
        end else begin
            s1_valid_q <= pix_valid;
            if (pix_valid) begin
                s1_pix_q <= pix_in;
                s1_win_q <= in_window_s;
                s1_lvl_q <= level_q;
            end
        end
    end

    // Stage 2 datapath: saturating dim, bit-replication expand, panel order {R,B,G}.
    always_comb begin
        eff_lvl_s = s1_win_q ? {LW{1'b0}} : s1_lvl_q;
        if (s1_valid_q) begin
            rgb_d = {expand8(dim_ch(s1_pix_q[3*IN_BITS-1 -: IN_BITS], eff_lvl_s)),
                     expand8(dim_ch(s1_pix_q[IN_BITS-1:0], eff_lvl_s)),
                     expand8(dim_ch(s1_pix_q[2*IN_BITS-1 -: IN_BITS], eff_lvl_s))};
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 24'h000000;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= s1_valid_q;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        rgb888    = rgb_q;
        rgb_valid = rgb_valid_q;
        dim_level = level_q;
        fade_busy = state_q[1];
    end
endmodule

// File: tb/tb_rgb_expand_dim.sv
// Testbench for rgb_expand_dim: directed test-plan steps plus randomized traffic checked every
// cycle against an arithmetic reference model of the fade and pixel pipeline.
module tb_rgb_expand_dim;
    localparam int IN_BITS     = 4;
    localparam int CW          = 12;
    localparam int WIN_X0      = 283;
    localparam int WIN_Y0      = 220;
    localparam int WIN_X1      = 483;
    localparam int WIN_Y1      = 355;
    localparam int DIM_MAX     = 2;
    localparam int FADE_FRAMES = 2;
    localparam int LW          = $clog2(DIM_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3*IN_BITS-1:0] pix_in;
    logic                 pix_valid;
    logic [CW-1:0]        hdata, vdata;
    logic                 frame_start, to_black;
    logic [23:0]          rgb888;
    logic                 rgb_valid;
    logic [LW-1:0]        dim_level;
    logic                 fade_busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_lvl, m_run, m_dir;
    bit m_v1, m_v2;
    int m_p1, m_rgb;

    rgb_expand_dim #(
        .IN_BITS(IN_BITS), .CW(CW), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
        .WIN_X1(WIN_X1), .WIN_Y1(WIN_Y1), .DIM_MAX(DIM_MAX), .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .hdata(hdata), .vdata(vdata), .frame_start(frame_start), .to_black(to_black),
        .rgb888(rgb888), .rgb_valid(rgb_valid), .dim_level(dim_level), .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int expand(int c);
        int acc = 0;
        for (int sh = 8 - IN_BITS; sh > -IN_BITS; sh -= IN_BITS)
            acc += (sh >= 0) ? (c << sh) : (c >> (-sh));
        return acc & 255;
    endfunction

    function automatic int dimv(int c, int l);
        return (c > l) ? c - l : 0;
    endfunction

    function automatic bit in_win(int h, int v);
`ifdef RGB_DIM_WINDOW_EN
        return (h >= WIN_X0) && (h <= WIN_X1) && (v >= WIN_Y0) && (v <= WIN_Y1);
`else
        return (h < 0) && (v < 0);
`endif
    endfunction

    function automatic int exp_pixel(int p, bit win, int lvl);
        int mask = (1 << IN_BITS) - 1;
        int l = win ? 0 : lvl;
        int r8 = expand(dimv((p >> (2*IN_BITS)) & mask, l));
        int g8 = expand(dimv((p >> IN_BITS) & mask, l));
        int b8 = expand(dimv(p & mask, l));
        return (r8 << 16) | (b8 << 8) | g8;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_run = 0; m_dir = 0;
        m_v1 = 1'b0; m_v2 = 1'b0; m_p1 = 0; m_rgb = 0;
    endtask

    task automatic model_frame();
        int tgt = to_black ? DIM_MAX : 0;
        int d;
        if (m_lvl == tgt) begin
            m_run = 0; m_dir = 0;
        end else begin
            d = (tgt > m_lvl) ? 1 : -1;
            m_run = (d == m_dir) ? m_run + 1 : 1;
            m_dir = d;
            if (m_run == FADE_FRAMES) begin
                m_lvl += d;
                m_run = 0;
                if (m_lvl == tgt) m_dir = 0;
            end
        end
    endtask

    // One clock: advance the model with the current inputs, then compare all outputs.
    task automatic tick();
        int np;
        m_v2 = m_v1;
        if (m_v1) m_rgb = m_p1;
        np = exp_pixel(int'(pix_in), in_win(int'(hdata), int'(vdata)), m_lvl);
        if (pix_valid) m_p1 = np;
        m_v1 = pix_valid;
        if (frame_start) model_frame();
        @(posedge clk);
        #1;
        check("rgb_valid", {31'd0, rgb_valid}, {31'd0, m_v2});
        check("rgb888", {8'd0, rgb888}, m_rgb);
        check("dim_level", 32'(dim_level), m_lvl);
        check("fade_busy", {31'd0, fade_busy}, (m_dir != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic fs();
        frame_start = 1'b1; tick();
        frame_start = 1'b0; tick(); tick();
    endtask

    task automatic send_pix(input logic [11:0] p, input int h, input int v,
                            input logic [23:0] expv, input string tag);
        pix_in = p; hdata = CW'(h); vdata = CW'(v); pix_valid = 1'b1; tick();
        pix_valid = 1'b0; tick();
        check({tag, "_valid"}, {31'd0, rgb_valid}, 32'd1);
        check(tag, {8'd0, rgb888}, {8'd0, expv});
        tick();
        check({tag, "_drop"}, {31'd0, rgb_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; hdata = '0; vdata = '0;
        frame_start = 1'b0; to_black = 1'b0;
        model_reset();
        #11;
        check("rst_rgb888", {8'd0, rgb888}, 32'd0);
        check("rst_rgb_valid", {31'd0, rgb_valid}, 32'd0);
        check("rst_dim_level", 32'(dim_level), 32'd0);
        check("rst_fade_busy", {31'd0, fade_busy}, 32'd0);
        #1 rst_n = 1'b1;

        // pass-through
        send_pix(12'hA5C, 0, 0, 24'hAACC55, "pass");

        // fade in
        to_black = 1'b1;
        fs(); check("fs1_busy", {31'd0, fade_busy}, 32'd1); check("fs1_lvl", 32'(dim_level), 32'd0);
        fs(); check("fs2_lvl", 32'(dim_level), 32'd1);
        fs();
        fs(); check("fs4_lvl", 32'(dim_level), 32'd2); check("fs4_busy", {31'd0, fade_busy}, 32'd0);

        // full dim and saturation
        send_pix(12'hA5C, 0, 0, 24'h88AA33, "dim");
        send_pix(12'h1F0, 0, 0, 24'h0000DD, "sat");
`ifdef RGB_DIM_WINDOW_EN
        send_pix(12'hA5C, 283, 220, 24'hAACC55, "win_tl");
        send_pix(12'hA5C, 483, 355, 24'hAACC55, "win_br");
`else
        send_pix(12'hA5C, 283, 220, 24'h88AA33, "win_tl");
        send_pix(12'hA5C, 483, 355, 24'h88AA33, "win_br");
`endif
        send_pix(12'hA5C, 484, 355, 24'h88AA33, "win_xout");
        send_pix(12'hA5C, 283, 219, 24'h88AA33, "win_yout");

        // fade out
        to_black = 1'b0;
        fs(); check("fs5_busy", {31'd0, fade_busy}, 32'd1);
        fs(); check("fs6_lvl", 32'(dim_level), 32'd1);
        fs();
        fs(); check("fs8_lvl", 32'(dim_level), 32'd0); check("fs8_busy", {31'd0, fade_busy}, 32'd0);

        // reversal mid-fade
        to_black = 1'b1;
        fs(); fs(); fs();
        check("rev3_lvl", 32'(dim_level), 32'd1);
        to_black = 1'b0;
        fs(); check("rev4_lvl", 32'(dim_level), 32'd1); check("rev4_busy", {31'd0, fade_busy}, 32'd1);
        fs(); check("rev5_lvl", 32'(dim_level), 32'd0); check("rev5_busy", {31'd0, fade_busy}, 32'd0);

        // async reset mid-fade with pixels in flight
        to_black = 1'b1;
        fs(); fs();
        pix_in = 12'h777; pix_valid = 1'b1; tick();
        pix_in = 12'hFFF; tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb888", {8'd0, rgb888}, 32'd0);
        check("arst_rgb_valid", {31'd0, rgb_valid}, 32'd0);
        check("arst_dim_level", 32'(dim_level), 32'd0);
        check("arst_fade_busy", {31'd0, fade_busy}, 32'd0);
        model_reset();
        pix_valid = 1'b0; to_black = 1'b0;
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        check("arst_no_stale", {31'd0, rgb_valid}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            pix_valid   = 1'($urandom_range(0, 1));
            pix_in      = 12'($urandom);
            hdata       = CW'($urandom_range(270, 500));
            vdata       = CW'($urandom_range(205, 370));
            frame_start = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) to_black = ~to_black;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
